// File: rtl/dma_transpose_pkg.sv
// Shared constants for the DMA transpose engine: register map, CTRL/STAT bit positions,
// FSM state encoding and a byte-lane merge helper.
package dma_transpose_pkg;

    localparam logic [2:0] REG_CTRL = 3'd0;
    localparam logic [2:0] REG_STAT = 3'd1;
    localparam logic [2:0] REG_SRC  = 3'd2;
    localparam logic [2:0] REG_DST  = 3'd3;
    localparam logic [2:0] REG_DIM  = 3'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_PRIO  = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    function automatic logic [15:0] byte_merge(input logic [15:0] cur,
                                               input logic [15:0] din,
                                               input logic [1:0]  we);
        byte_merge = {(we[1] ? din[15:8] : cur[15:8]), (we[0] ? din[7:0] : cur[7:0])};
    endfunction

endpackage

// File: rtl/dma_transpose_regs.sv
// Register window of the DMA transpose engine: decode, byte-enabled writes, W1C status
// and the OR-bus read mux. IE/irq exist only when DMA_TRANSPOSE_IRQ_EN is defined.
module dma_transpose_regs
    import dma_transpose_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0190
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic        busy,
    input  logic        set_done,
    input  logic        set_err,
    output logic        start,
    output logic [14:0] src_word,
    output logic [14:0] dst_word,
    output logic [7:0]  dim_n,
    output logic [7:0]  dim_m,
    output logic        prio,
    output logic        irq
);

    logic        sel_s, wr_s, rd_s;
    logic [2:0]  off_s;
    logic        ctrl_w_s, stat_w_s, src_w_s, dst_w_s, dim_w_s;
    logic        ie_r, ie_nxt, prio_r, prio_nxt;
    logic        done_r, done_nxt, err_r, err_nxt, irq_r, irq_nxt;
    logic [15:0] src_r, src_nxt, dst_r, dst_nxt, dim_r, dim_nxt;

    // The 16-byte window spans 8 words, so word address bits [13:3] select the block.
    assign sel_s    = per_en && (per_addr[13:3] == BASE_ADDR[14:4]);
    assign off_s    = per_addr[2:0];
    assign wr_s     = sel_s && (per_we != 2'b00);
    assign rd_s     = sel_s && (per_we == 2'b00);
    assign ctrl_w_s = wr_s && (off_s == REG_CTRL) && per_we[0];
    assign stat_w_s = wr_s && (off_s == REG_STAT) && per_we[0];
    assign src_w_s  = wr_s && (off_s == REG_SRC) && !busy;
    assign dst_w_s  = wr_s && (off_s == REG_DST) && !busy;
    assign dim_w_s  = wr_s && (off_s == REG_DIM) && !busy;
    assign start    = ctrl_w_s && per_din[CTRL_START] && !busy;

    // Next-state values for every register; a same-cycle set beats a W1C clear.
    always_comb begin
        prio_nxt = ctrl_w_s ? per_din[CTRL_PRIO] : prio_r;
        src_nxt  = src_w_s ? byte_merge(src_r, per_din, per_we) : src_r;
        dst_nxt  = dst_w_s ? byte_merge(dst_r, per_din, per_we) : dst_r;
        dim_nxt  = dim_w_s ? byte_merge(dim_r, per_din, per_we) : dim_r;
        done_nxt = set_done | (done_r & ~(stat_w_s & per_din[STAT_DONE]));
        err_nxt  = set_err  | (err_r  & ~(stat_w_s & per_din[STAT_ERR]));
`ifdef DMA_TRANSPOSE_IRQ_EN
        ie_nxt   = ctrl_w_s ? per_din[CTRL_IE] : ie_r;
        irq_nxt  = ie_nxt & (done_nxt | err_nxt);
`else
        ie_nxt   = 1'b0;
        irq_nxt  = 1'b0;
`endif
    end

    // Register state, including the registered interrupt level.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            ie_r   <= 1'b0;
            prio_r <= 1'b0;
            src_r  <= 16'h0000;
            dst_r  <= 16'h0000;
            dim_r  <= 16'h0000;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            ie_r   <= ie_nxt;
            prio_r <= prio_nxt;
            src_r  <= src_nxt;
            dst_r  <= dst_nxt;
            dim_r  <= dim_nxt;
            done_r <= done_nxt;
            err_r  <= err_nxt;
            irq_r  <= irq_nxt;
        end
    end

    // Read mux; drives 0 when not selected so the bus can be OR-combined.
    always_comb begin
        per_dout = 16'h0000;
        if (rd_s) begin
            case (off_s)
                REG_CTRL: per_dout = {13'h0000, prio_r, ie_r, 1'b0};
                REG_STAT: per_dout = {13'h0000, err_r, done_r, busy};
                REG_SRC:  per_dout = src_r;
                REG_DST:  per_dout = dst_r;
                REG_DIM:  per_dout = dim_r;
                default:  per_dout = 16'h0000;
            endcase
        end else begin
            per_dout = 16'h0000;
        end
    end

    assign src_word = src_r[15:1];
    assign dst_word = dst_r[15:1];
    assign dim_n    = dim_r[7:0];
    assign dim_m    = dim_r[15:8];
    assign prio     = prio_r;
    assign irq      = irq_r;

endmodule

// File: rtl/dma_transpose.sv
// DMA matrix transpose engine: reads an N x M row-major matrix at SRC and writes its
// transpose at DST. Optional interrupt support via `define DMA_TRANSPOSE_IRQ_EN.
module dma_transpose
    import dma_transpose_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0190
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    output logic [14:0] dma_addr,
    output logic [15:0] dma_din,
    output logic        dma_en,
    output logic [1:0]  dma_we,
    output logic        dma_priority,
    input  logic [15:0] dma_dout,
    input  logic        dma_ready,
    input  logic        dma_resp,
    output logic        irq
);

    state_t      state_r, state_nxt;
    logic [14:0] rd_ptr_r, rd_ptr_nxt, wr_ptr_r, wr_ptr_nxt, row_base_r, row_base_nxt;
    logic [7:0]  row_r, row_nxt, col_r, col_nxt;
    logic        busy_s, start_s, set_done_s, set_err_s, row_last_s, col_last_s;
    logic [14:0] src_s, dst_s, n_ext_s;
    logic [7:0]  n_s, m_s;
    logic        dma_en_r, prio_s;
    logic [1:0]  dma_we_r;
    logic [14:0] dma_addr_r;
    logic [15:0] dma_din_r;

    dma_transpose_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
        .mclk     (mclk),
        .reset_n  (reset_n),
        .per_addr (per_addr),
        .per_din  (per_din),
        .per_en   (per_en),
        .per_we   (per_we),
        .per_dout (per_dout),
        .busy     (busy_s),
        .set_done (set_done_s),
        .set_err  (set_err_s),
        .start    (start_s),
        .src_word (src_s),
        .dst_word (dst_s),
        .dim_n    (n_s),
        .dim_m    (m_s),
        .prio     (prio_s),
        .irq      (irq)
    );

    assign busy_s     = (state_r != ST_IDLE);
    assign n_ext_s    = {7'd0, n_s};
    assign row_last_s = (row_r == (n_s - 8'd1));
    assign col_last_s = (col_r == (m_s - 8'd1));

    // Next state and address generation; the write pointer strides by N and rebases per row.
    always_comb begin
        state_nxt    = state_r;
        rd_ptr_nxt   = rd_ptr_r;
        wr_ptr_nxt   = wr_ptr_r;
        row_base_nxt = row_base_r;
        row_nxt      = row_r;
        col_nxt      = col_r;
        set_done_s   = 1'b0;
        set_err_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if ((n_s == 8'd0) || (m_s == 8'd0)) begin
                        set_done_s = 1'b1;
                    end else begin
                        state_nxt    = ST_RD;
                        rd_ptr_nxt   = src_s;
                        wr_ptr_nxt   = dst_s;
                        row_base_nxt = dst_s;
                        row_nxt      = 8'd0;
                        col_nxt      = 8'd0;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD: begin
                if (dma_ready) begin
                    if (dma_resp) begin
                        state_nxt = ST_IDLE;
                        set_err_s = 1'b1;
                    end else begin
                        state_nxt  = ST_CAP;
                        rd_ptr_nxt = rd_ptr_r + 15'd1;
                    end
                end else begin
                    state_nxt = ST_RD;
                end
            end
            ST_CAP: state_nxt = ST_WR;
            ST_WR: begin
                if (dma_ready) begin
                    if (dma_resp) begin
                        state_nxt = ST_IDLE;
                        set_err_s = 1'b1;
                    end else if (row_last_s && col_last_s) begin
                        state_nxt  = ST_IDLE;
                        set_done_s = 1'b1;
                    end else if (col_last_s) begin
                        state_nxt    = ST_RD;
                        col_nxt      = 8'd0;
                        row_nxt      = row_r + 8'd1;
                        row_base_nxt = row_base_r + 15'd1;
                        wr_ptr_nxt   = row_base_r + 15'd1;
                    end else begin
                        state_nxt  = ST_RD;
                        col_nxt    = col_r + 8'd1;
                        wr_ptr_nxt = wr_ptr_r + n_ext_s;
                    end
                end else begin
                    state_nxt = ST_WR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM, pointers and registered DMA request derived from the next state.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            rd_ptr_r   <= 15'd0;
            wr_ptr_r   <= 15'd0;
            row_base_r <= 15'd0;
            row_r      <= 8'd0;
            col_r      <= 8'd0;
            dma_en_r   <= 1'b0;
            dma_we_r   <= 2'b00;
            dma_addr_r <= 15'd0;
            dma_din_r  <= 16'h0000;
        end else begin
            state_r    <= state_nxt;
            rd_ptr_r   <= rd_ptr_nxt;
            wr_ptr_r   <= wr_ptr_nxt;
            row_base_r <= row_base_nxt;
            row_r      <= row_nxt;
            col_r      <= col_nxt;
            dma_en_r   <= (state_nxt == ST_RD) || (state_nxt == ST_WR);
            dma_we_r   <= (state_nxt == ST_WR) ? 2'b11 : 2'b00;
            dma_addr_r <= (state_nxt == ST_RD) ? rd_ptr_nxt :
                          (state_nxt == ST_WR) ? wr_ptr_nxt : 15'd0;
            dma_din_r  <= (state_r == ST_CAP) ? dma_dout : dma_din_r;
        end
    end

    assign dma_en       = dma_en_r;
    assign dma_we       = dma_we_r;
    assign dma_addr     = dma_addr_r;
    assign dma_din      = dma_din_r;
    assign dma_priority = prio_s;

endmodule

// File: tb/tb_dma_transpose.sv
// Directed bench for dma_transpose: memory responder with wait-state/error injection and a
// write scoreboard fed from an independent transpose model.
module tb_dma_transpose;

    localparam logic [13:0] BASE_W = 14'h00C8;
    localparam logic [2:0] O_CTRL = 3'd0, O_STAT = 3'd1, O_SRC = 3'd2, O_DST = 3'd3, O_DIM = 3'd4;
`ifdef DMA_TRANSPOSE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        mclk, reset_n, per_en, dma_en, dma_priority, dma_ready, dma_resp, irq;
    logic [13:0] per_addr;
    logic [15:0] per_din, per_dout, dma_din, dma_dout;
    logic [1:0]  per_we, dma_we;
    logic [14:0] dma_addr;

    typedef struct packed { logic [14:0] a; logic [15:0] d; } wr_t;
    wr_t         sb_q[$];
    logic [15:0] mem [0:32767];
    int          n_cmp = 0, n_bad = 0;
    int          ws = 0, err_at = 0, acc_cnt = 0, en_cnt = 0;

    dma_transpose #(.BASE_ADDR(15'h0190)) dut (
        .mclk(mclk), .reset_n(reset_n), .per_addr(per_addr), .per_din(per_din),
        .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .dma_addr(dma_addr),
        .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we), .dma_priority(dma_priority),
        .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp), .irq(irq)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic per_write(input logic [2:0] off, input logic [15:0] d);
        per_en = 1'b1; per_we = 2'b11; per_addr = BASE_W + {11'd0, off}; per_din = d;
        @(negedge mclk);
        per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic per_read(input logic [2:0] off, output logic [15:0] v);
        per_en = 1'b1; per_we = 2'b00; per_addr = BASE_W + {11'd0, off};
        #1 v = per_dout;
        per_en = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output logic [15:0] v);
        for (int i = 0; i < bound; i++) begin
            per_read(O_STAT, v);
            if (!v[0]) break;
            @(negedge mclk);
        end
        check("idle_timeout", 32'(v[0]), 32'd0);
    endtask

    // Reference transpose: element (r,c) of the source lands at dst + c*N + r.
    task automatic push_expect(input logic [14:0] s, input logic [14:0] dd, input int n, input int m);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < m; c++) begin
                wr_t x;
                x.a = dd + 15'(c * n + r);
                x.d = mem[s + 15'(r * m + c)];
                sb_q.push_back(x);
            end
        end
    endtask

    // Memory responder: decides ready/resp on the falling edge, applies accepted accesses after the rising edge.
    initial begin : responder
        bit          pend, waiting, e;
        logic [14:0] a;
        logic [1:0]  w;
        logic [15:0] d;
        int          wc;
        wr_t         x;
        pend = 1'b0; waiting = 1'b0; wc = 0; e = 1'b0;
        a = 15'd0; w = 2'b00; d = 16'h0000;
        dma_ready = 1'b1; dma_resp = 1'b0; dma_dout = 16'h0000;
        forever begin
            @(negedge mclk);
            if (dma_en) en_cnt++;
            if (waiting && dma_en) begin
                check("hold_addr", 32'(dma_addr), 32'(a));
                check("hold_we", 32'(dma_we), 32'(w));
            end
            waiting = 1'b0; pend = 1'b0; dma_resp = 1'b0;
            if (dma_en) begin
                if (wc < ws) begin
                    dma_ready = 1'b0; wc++; waiting = 1'b1;
                end else begin
                    dma_ready = 1'b1; wc = 0; pend = 1'b1;
                    dma_resp = ((acc_cnt + 1) == err_at);
                end
                a = dma_addr; w = dma_we; d = dma_din;
            end else begin
                dma_ready = (ws == 0);
            end
            e = dma_resp;
            @(posedge mclk);
            #1;
            if (pend && reset_n) begin
                acc_cnt++;
                if (!e) begin
                    if (w == 2'b00) begin
                        dma_dout = mem[a];
                    end else begin
                        mem[a] = d;
                        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                        if (sb_q.size() > 0) begin
                            x = sb_q.pop_front();
                            check("wr_addr", 32'(a), 32'(x.a));
                            check("wr_data", 32'(d), 32'(x.d));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] v;
        logic [15:0] exp_tbl [0:5];
        int          cnt, base_en, base_acc;
        bit          found;
        exp_tbl[0] = 16'd1; exp_tbl[1] = 16'd4; exp_tbl[2] = 16'd2;
        exp_tbl[3] = 16'd5; exp_tbl[4] = 16'd3; exp_tbl[5] = 16'd6;
        reset_n = 1'b0; per_en = 1'b0; per_we = 2'b00; per_addr = 14'd0; per_din = 16'h0000;
        for (int k = 0; k < 6; k++) mem[15'h0100 + 15'(k)] = 16'(k + 1);

        // Reset state
        repeat (3) @(negedge mclk);
        check("rst_dma_en", 32'(dma_en), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        per_read(O_STAT, v);
        check("rst_dout", 32'(v), 32'd0);
        reset_n = 1'b1;
        @(negedge mclk);
        per_read(O_STAT, v);
        check("stat_after_rst", 32'(v), 32'h0000);

        // 2x3 transfer, zero wait states
        per_write(O_SRC, 16'h0200);
        per_write(O_DST, 16'h0300);
        per_write(O_DIM, 16'h0302);
        push_expect(15'h0100, 15'h0180, 2, 3);
        per_write(O_CTRL, 16'h0003);
        check("first_en", 32'(dma_en), 32'd1);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            per_read(O_STAT, v);
            if (!v[0]) break;
            cnt++;
            @(negedge mclk);
        end
        check("busy_cycles", 32'(cnt), 32'd18);
        check("stat_done", 32'(v), 32'h0002);
        check("irq_done", 32'(irq), 32'(IRQ_ON));
        per_read(O_CTRL, v);
        check("ctrl_read", 32'(v), IRQ_ON ? 32'h0002 : 32'h0000);
        for (int i = 0; i < 6; i++) check("dst_mem", 32'(mem[15'h0180 + 15'(i)]), 32'(exp_tbl[i]));
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        per_write(O_STAT, 16'h0002);
        per_read(O_STAT, v);
        check("done_w1c", 32'(v), 32'h0000);
        check("irq_cleared", 32'(irq), 32'd0);

        // Same transfer with two wait states per access; DST write while busy is ignored
        for (int i = 0; i < 6; i++) mem[15'h0180 + 15'(i)] = 16'h0000;
        ws = 2;
        push_expect(15'h0100, 15'h0180, 2, 3);
        per_write(O_CTRL, 16'h0003);
        per_write(O_DST, 16'h0400);
        wait_idle(500, v);
        check("ws_stat", 32'(v), 32'h0002);
        for (int i = 0; i < 6; i++) check("ws_dst_mem", 32'(mem[15'h0180 + 15'(i)]), 32'(exp_tbl[i]));
        check("ws_sb_drained", 32'(sb_q.size()), 32'd0);
        per_read(O_DST, v);
        check("dst_locked", 32'(v), 32'h0300);
        ws = 0;
        per_write(O_STAT, 16'h0002);

        // Error response on the third accepted access (second read)
        err_at = acc_cnt + 3;
        begin
            wr_t x;
            x.a = 15'h0180; x.d = mem[15'h0100];
            sb_q.push_back(x);
        end
        per_write(O_CTRL, 16'h0001);
        wait_idle(200, v);
        check("err_stat", 32'(v), 32'h0004);
        base_en = en_cnt;
        repeat (10) @(negedge mclk);
        check("err_no_en", 32'(en_cnt - base_en), 32'd0);
        check("err_sb", 32'(sb_q.size()), 32'd0);
        check("err_irq_masked", 32'(irq), 32'd0);
        err_at = 0;
        per_write(O_STAT, 16'h0004);
        per_read(O_STAT, v);
        check("err_w1c", 32'(v), 32'h0000);

        // Zero-sized transfer
        per_write(O_DIM, 16'h0500);
        base_en = en_cnt; base_acc = acc_cnt;
        per_write(O_CTRL, 16'h0001);
        per_read(O_STAT, v);
        check("zero_done", 32'(v), 32'h0002);
        repeat (5) @(negedge mclk);
        check("zero_no_en", 32'(en_cnt - base_en), 32'd0);
        check("zero_no_acc", 32'(acc_cnt - base_acc), 32'd0);
        per_write(O_STAT, 16'h0002);

        // Reset during the first write access
        per_write(O_DIM, 16'h0302);
        per_write(O_CTRL, 16'h0001);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (dma_en && (dma_we != 2'b00)) begin
                found = 1'b1;
                break;
            end
            @(negedge mclk);
        end
        check("wr_reached", 32'(found), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_en", 32'(dma_en), 32'd0);
        check("rst_mid_we", 32'(dma_we), 32'd0);
        check("rst_mid_addr", 32'(dma_addr), 32'd0);
        @(negedge mclk);
        @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
        per_read(O_STAT, v);
        check("rst_mid_stat", 32'(v), 32'h0000);
        base_en = en_cnt;
        repeat (5) @(negedge mclk);
        check("rst_mid_no_en", 32'(en_cnt - base_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dma_transpose.md
DMA_TRANSPOSE -- requirements
Module: dma_transpose

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h0190, byte base address of the 16-byte register window.
REQ-002 SHALL have port mclk  input  1  system clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port per_addr  input  14  peripheral word address.
REQ-005 SHALL have port per_din  input  16  peripheral write data.
REQ-006 SHALL have port per_en  input  1  peripheral access enable.
REQ-007 SHALL have port per_we  input  2  byte write enables: bit0 is the low byte, bit1 is the high byte.
REQ-008 SHALL have port per_dout  output  16  register read data; 0 when not selected (OR-bus).
REQ-009 SHALL have port dma_addr  output  15  DMA word address.
REQ-010 SHALL have port dma_din  output  16  DMA write data.
REQ-011 SHALL have port dma_en  output  1  DMA request.
REQ-012 SHALL have port dma_we  output  2  DMA byte write enables; 00 means read.
REQ-013 SHALL have port dma_priority  output  1  copy of CTRL.PRIO.
REQ-014 SHALL have port dma_dout  input  16  DMA read data, valid the cycle after read acceptance.
REQ-015 SHALL have port dma_ready  input  1  the current request is accepted in this cycle.
REQ-016 SHALL have port dma_resp  input  1  error flag, sampled with dma_ready.
REQ-017 SHALL have port irq  output  1  level interrupt: done or error.

Function
REQ-018 SHALL decode word offsets 0 CTRL (bit0 START, bit1 IE, bit2 PRIO), 1 STAT (bit0 BUSY, bit1 DONE, bit2 ERR), 2 SRC, 3 DST and 4 DIM (rows N[7:0], cols M[15:8]); other offsets read 0.
REQ-019 SHALL treat SRC and DST as byte addresses and use bits [15:1] as word addresses.
REQ-020 SHALL return per_dout combinationally when per_en is 1 and per_we is 00; START SHALL read as 0.
REQ-021 SHALL make DONE and ERR write-1-to-clear.
REQ-022 SHALL ignore writes to SRC, DST, DIM and START while BUSY is 1.
REQ-023 SHALL use FSM states IDLE, RD, CAP, WR, with IDLE->RD on a START write that sets BIT0.
REQ-024 SHALL hold dma_addr and dma_we stable with dma_en=1 in RD and WR until dma_ready=1.
REQ-025 SHALL go RD->CAP on dma_ready, latch dma_dout in CAP, then go CAP->WR unconditionally.
REQ-026 SHALL read source element k from word SRC+k, for k = 0 .. N*M-1, in row-major order.
REQ-027 SHALL write the element at row r, column c to word DST+c*N+r, generated by adding N at each step and rebasing to DST+r+1 at each row end; no multiplier.
REQ-028 SHALL wrap all address arithmetic modulo 2^15.
REQ-029 SHALL, on accepting the last write, go WR->IDLE, clear BUSY and set DONE in the next cycle.
REQ-030 SHALL, on dma_ready with dma_resp=1, go to IDLE, clear BUSY, set ERR and issue no further requests.
REQ-031 SHALL, when START is written with N=0 or M=0, set DONE in the next cycle with no DMA access.
REQ-032 SHALL, with dma_ready tied to 1, raise the first dma_en one cycle after the START write and take 3 cycles per element.
REQ-033 SHALL drive irq = IE & (DONE | ERR).

Reset
REQ-034 SHALL, while reset_n=0, force all registers to 0, the FSM to IDLE, and dma_en, dma_we, dma_addr, dma_din, irq and per_dout to 0, asynchronously.
REQ-035 SHALL, when reset is asserted mid-transfer, abandon the transfer with no pending request after release.

Configuration
REQ-036 SHALL, with DMA_TRANSPOSE_IRQ_EN defined, implement the IE bit and irq per REQ-033.
REQ-037 SHALL, without DMA_TRANSPOSE_IRQ_EN, tie irq to 0 and make IE read 0 and ignore writes.

Structure
REQ-038 SHALL place the register offsets, CTRL/STAT bit positions and FSM state encodings in shared package dma_transpose_pkg.
REQ-039 SHALL implement the register decode and per_dout in sub-module dma_transpose_regs; the FSM and address generators SHALL be in dma_transpose.

Verification
REQ-040 SHALL cover reset: after reset, STAT reads 0000, dma_en=0 and irq=0.
REQ-041 SHALL cover a 2x3 transfer: SRC=0x0200 holds 1..6, DST=0x0300, DIM=0x0302, dma_ready=1 -> DST holds 1,4,2,5,3,6; BUSY lasts 18 cycles; DONE=1; irq=1 with IE set.
REQ-042 SHALL cover wait states: same transfer with dma_ready low 2 cycles per access -> addr and we stay stable and the result is identical.
REQ-043 SHALL cover an error: dma_resp=1 on the 3rd accepted access -> ERR=1, BUSY=0, no further dma_en.
REQ-044 SHALL cover zero size: DIM=0x0500 with START -> DONE the next cycle, dma_en never asserted.
REQ-045 SHALL cover reset mid-transfer: reset_n low during WR -> dma_en=0 in the same cycle and STAT reads 0000 after release.
